// File: rtl/row_window_gen.sv
// 3-row line buffer emitting one 3x3 window per output pixel in raster order; first window the cycle after the priming row.
// Windows hold under win_ready_i=0; rows are refused while emitting. `WIN_PAD_EN: zero-padded borders, else interior windows only.
module row_window_gen #(
  parameter int DW = 32,
  parameter int DP = 56,
  parameter int H  = 56
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW*DP-1:0]  row_i,
  input  logic              row_valid_i,
  output logic              row_ready_o,
  output logic [9*DW-1:0]   win_o,
  output logic              win_valid_o,
  input  logic              win_ready_i,
  output logic [7:0]        win_row_o,
  output logic [7:0]        win_col_o,
  output logic              frame_done_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT, EMIT} state_t;

`ifdef WIN_PAD_EN
  localparam state_t         AFTER_ROW0 = WAIT;
  localparam logic [7:0]     FIRST_ROW  = 8'd0;
  localparam logic [7:0]     FIRST_COL  = 8'd0;
  localparam logic [7:0]     LAST_COL   = 8'(DP - 1);
`else
  // Interior-only mode needs two rows buffered before the first centre row.
  localparam state_t         AFTER_ROW0 = FILL;
  localparam logic [7:0]     FIRST_ROW  = 8'd1;
  localparam logic [7:0]     FIRST_COL  = 8'd1;
  localparam logic [7:0]     LAST_COL   = 8'(DP - 2);
`endif
  localparam logic [7:0]     PEN_ROW    = 8'(H - 2);

  state_t            state, state_nx;
  logic [DW*DP-1:0]  top, mid, bot;
  logic [7:0]        out_row, col;
  logic              frame_done, overflow;
  logic              row_rdy, win_vld, row_end, zero_shift, frame_end;
  logic              accept, fire;

  assign accept = row_valid_i & row_rdy;
  assign fire   = win_vld & win_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    row_rdy    = 1'b0;
    win_vld    = 1'b0;
    row_end    = 1'b0;
    zero_shift = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        row_rdy = 1'b1;
        if (row_valid_i) state_nx = AFTER_ROW0;
      end
      FILL: begin
        row_rdy = 1'b1;
        if (row_valid_i) state_nx = WAIT;
      end
      WAIT: begin
        row_rdy = 1'b1;
        if (row_valid_i) state_nx = EMIT;
      end
      EMIT: begin
        win_vld = 1'b1;
        if (win_ready_i && col == LAST_COL) begin
          if (out_row < PEN_ROW) begin
            row_end  = 1'b1;
            state_nx = WAIT;
          end
`ifdef WIN_PAD_EN
          else if (out_row == PEN_ROW) zero_shift = 1'b1;
`endif
          else begin
            frame_end = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top        <= '0;
      mid        <= '0;
      bot        <= '0;
      out_row    <= '0;
      col        <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (row_valid_i && !row_rdy) overflow <= 1'b1;
      if (frame_end) begin
        top     <= '0;
        mid     <= '0;
        bot     <= '0;
        out_row <= '0;
        col     <= '0;
      end else begin
        if (accept) begin
          top <= mid;
          mid <= bot;
          bot <= row_i;
        end else if (zero_shift) begin
          top <= mid;
          mid <= bot;
          bot <= '0;
        end
        if (accept && state == IDLE) out_row <= FIRST_ROW;
        if (accept && state == WAIT) col <= FIRST_COL;
        if (fire) begin
          if (col != LAST_COL) begin
            col <= col + 8'd1;
          end else begin
            col     <= FIRST_COL;
            out_row <= row_end ? out_row + 8'd1 : 8'(H - 1);
          end
        end
      end
    end
  end

  // Window element (k,j) reads column col-1+j; a 9-bit compare keeps col-1 = -1 from aliasing column 255.
  logic [DW*DP-1:0] lines [3];
  logic [8:0]       col_x;
  assign lines[0] = top;
  assign lines[1] = mid;
  assign lines[2] = bot;
  assign col_x    = {1'b0, col};

  for (genvar k = 0; k < 3; k++) begin : g_k
    for (genvar j = 0; j < 3; j++) begin : g_j
      logic [DP-1:0][DW-1:0] terms;
      logic [DW-1:0][DP-1:0] bits_t;
      for (genvar c = 0; c < DP; c++) begin : g_c
        assign terms[c] = (col_x == 9'(c + 1 - j)) ? lines[k][c*DW +: DW] : '0;
        for (genvar b = 0; b < DW; b++) begin : g_b
          assign bits_t[b][c] = terms[c][b];
        end
      end
      for (genvar b = 0; b < DW; b++) begin : g_o
        assign win_o[(k*3+j)*DW + b] = (state == EMIT) & (|bits_t[b]);
      end
    end
  end

  assign row_ready_o  = row_rdy;
  assign win_valid_o  = win_vld;
  assign win_row_o    = out_row;
  assign win_col_o    = col;
  assign frame_done_o = frame_done;
  assign overflow_o   = overflow;

endmodule

// File: tb/tb_row_window_gen.sv
// Scoreboard bench for row_window_gen: expected windows queued per frame, popped on each accepted window.
`timescale 1ns/1ps
module tb_row_window_gen;
  localparam int DW = 32;
  localparam int DP = 4;
`ifdef WIN_PAD_EN
  localparam int H   = 3;
  localparam bit PAD = 1'b1;
`else
  localparam int H   = 4;
  localparam bit PAD = 1'b0;
`endif
  localparam int R0   = PAD ? 0 : 1;
  localparam int R1   = PAD ? H - 1 : H - 2;
  localparam int C0   = PAD ? 0 : 1;
  localparam int C1   = PAD ? DP - 1 : DP - 2;
  localparam int NWIN = (R1 - R0 + 1) * (C1 - C0 + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW*DP-1:0]  row_i;
  logic              row_valid_i;
  logic              row_ready_o;
  logic [9*DW-1:0]   win_o;
  logic              win_valid_o;
  logic              win_ready_i;
  logic [7:0]        win_row_o;
  logic [7:0]        win_col_o;
  logic              frame_done_o;
  logic              overflow_o;

  row_window_gen #(.DW(DW), .DP(DP), .H(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_i        (row_i),
    .row_valid_i  (row_valid_i),
    .row_ready_o  (row_ready_o),
    .win_o        (win_o),
    .win_valid_o  (win_valid_o),
    .win_ready_i  (win_ready_i),
    .win_row_o    (win_row_o),
    .win_col_o    (win_col_o),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9*DW-1:0] win;
    logic [7:0]      r;
    logic [7:0]      c;
    bit              last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   win_cnt = 0;
  int   done_cnt = 0;
  bit   prev_last = 1'b0;

  function automatic logic [DW-1:0] pix(input int r, input int c);
    logic [15:0] rr, cc;
    if (r < 0 || r >= H || c < 0 || c >= DP) return '0;
    rr = 16'(r);
    cc = 16'(c);
    return {rr, cc};
  endfunction

  function automatic logic [DW*DP-1:0] mk_row(input int r);
    logic [DW*DP-1:0] v;
    v = '0;
    for (int c = DP - 1; c >= 0; c--) v = {v[DW*(DP-1)-1:0], pix(r, c)};
    return v;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int r = R0; r <= R1; r++) begin
      for (int c = C0; c <= C1; c++) begin
        e.win = '0;
        for (int k = 2; k >= 0; k--)
          for (int j = 2; j >= 0; j--)
            e.win = {e.win[8*DW-1:0], pix(r - 1 + k, c - 1 + j)};
        e.r    = 8'(r);
        e.c    = 8'(c);
        e.last = (r == R1 && c == C1);
        q.push_back(e);
      end
    end
  endtask

  // Call at a falling edge.
  task automatic send_row(input int r, input bit hold);
    int n;
    n = 0;
    row_i = mk_row(r);
    if (hold) row_valid_i = 1'b1;
    while (!row_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!row_ready_o) begin
      tests++; fails++;
      $display("FAIL row_accept_timeout: row %0d ready=%0b after %0d cycles, required 1", r, row_ready_o, n);
    end
    row_valid_i = 1'b1;
    @(negedge clk);
    if (!hold) row_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int done_before);
    int n;
    n = 0;
    while (done_cnt == done_before && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (3) begin
      @(posedge clk); #2;
    end
  endtask

  always @(negedge clk) begin
    bit   cur_last;
    exp_t e;
    cur_last = 1'b0;
    if (rst_n) begin
      if (frame_done_o) begin
        done_cnt++;
        tests++;
        if (prev_last !== 1'b1) begin
          fails++;
          $display("FAIL frame_done_timing: previous-cycle final accept=%0b, required 1", prev_last);
        end
      end
      if (win_valid_o && win_ready_i) begin
        win_cnt++;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL window_extra: got row %0d col %0d, required no window", win_row_o, win_col_o);
        end else begin
          e = q.pop_front();
          cur_last = e.last;
          if (win_o !== e.win || win_row_o !== e.r || win_col_o !== e.c) begin
            fails++;
            $display("FAIL window: got (%0d,%0d) %h, required (%0d,%0d) %h",
                     win_row_o, win_col_o, win_o, e.r, e.c, e.win);
          end
        end
      end
    end
    prev_last = cur_last;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    row_valid_i = 1'b0;
    row_i = '0;
    win_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (row_ready_o !== 1'b1) begin fails++; $display("FAIL reset_row_ready: got %b, required 1", row_ready_o); end
    tests++; if (win_valid_o !== 1'b0) begin fails++; $display("FAIL reset_win_valid: got %b, required 0", win_valid_o); end
    tests++; if (win_o !== '0) begin fails++; $display("FAIL reset_win: got %h, required 0", win_o); end
    tests++; if (win_row_o !== 8'd0) begin fails++; $display("FAIL reset_win_row: got %0d, required 0", win_row_o); end
    tests++; if (win_col_o !== 8'd0) begin fails++; $display("FAIL reset_win_col: got %0d, required 0", win_col_o); end
    tests++; if (frame_done_o !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b, required 0", frame_done_o); end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", overflow_o); end
  endtask

  task automatic test_frame();
    int d0, w0, n;
    logic [9*DW-1:0] first_exp;
    d0 = done_cnt;
    w0 = win_cnt;
    if (PAD)
      first_exp = {32'h00010001, 32'h00010000, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    else
      first_exp = {32'h00020002, 32'h00020001, 32'h00020000, 32'h00010002, 32'h00010001,
                   32'h00010000, 32'h00000002, 32'h00000001, 32'h00000000};
    @(negedge clk);
    push_frame();
    fork
      begin
        for (int r = 0; r < H; r++) send_row(r, 1'b0);
      end
      begin
        n = 0;
        while (!win_valid_o && n < 200) begin
          @(posedge clk); #2;
          n++;
        end
        tests++;
        if (win_o !== first_exp || win_row_o !== 8'(R0) || win_col_o !== 8'(C0)) begin
          fails++;
          $display("FAIL first_window: got (%0d,%0d) %h, required (%0d,%0d) %h",
                   win_row_o, win_col_o, win_o, R0, C0, first_exp);
        end
      end
    join
    wait_done(d0);
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL frame_done_count: got %0d, required 1", done_cnt - d0); end
    tests++; if (win_cnt - w0 != NWIN) begin fails++; $display("FAIL frame_window_count: got %0d, required %0d", win_cnt - w0, NWIN); end
    tests++; if (q.size() != 0) begin fails++; $display("FAIL frame_leftover: got %0d pending, required 0", q.size()); end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL frame_overflow: got %b, required 0", overflow_o); end
  endtask

  task automatic test_backpressure();
    int d0, w0, n;
    logic [9*DW-1:0] hw;
    logic [7:0]      hr, hc;
    d0 = done_cnt;
    w0 = win_cnt;
    @(negedge clk);
    push_frame();
    fork
      begin
        for (int r = 0; r < H; r++) send_row(r, 1'b0);
      end
      begin
        n = 0;
        while (!(win_valid_o && win_row_o == 8'(R0) && win_col_o == 8'(C0 + 1)) && n < 200) begin
          @(posedge clk); #2;
          n++;
        end
        win_ready_i = 1'b0;
        hw = win_o;
        hr = win_row_o;
        hc = win_col_o;
        tests++;
        if (hr !== 8'(R0) || hc !== 8'(C0 + 1)) begin
          fails++;
          $display("FAIL bp_stall_point: got (%0d,%0d), required (%0d,%0d)", hr, hc, R0, C0 + 1);
        end
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #2;
          tests++;
          if (win_valid_o !== 1'b1 || win_o !== hw || win_row_o !== hr || win_col_o !== hc) begin
            fails++;
            $display("FAIL bp_hold: cycle %0d got v=%b (%0d,%0d) %h, required v=1 (%0d,%0d) %h",
                     i, win_valid_o, win_row_o, win_col_o, win_o, hr, hc, hw);
          end
        end
        win_ready_i = 1'b1;
      end
    join
    wait_done(d0);
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL bp_done_count: got %0d, required 1", done_cnt - d0); end
    tests++; if (win_cnt - w0 != NWIN) begin fails++; $display("FAIL bp_window_count: got %0d, required %0d", win_cnt - w0, NWIN); end
    tests++; if (q.size() != 0) begin fails++; $display("FAIL bp_leftover: got %0d pending, required 0", q.size()); end
  endtask

  task automatic test_overflow();
    int d0, w0;
    d0 = done_cnt;
    w0 = win_cnt;
    @(negedge clk);
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL ovf_before: got %b, required 0", overflow_o); end
    push_frame();
    for (int r = 0; r < H; r++) send_row(r, 1'b1);
    row_valid_i = 1'b0;
    wait_done(d0);
    tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b, required 1", overflow_o); end
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL ovf_done_count: got %0d, required 1", done_cnt - d0); end
    tests++; if (win_cnt - w0 != NWIN) begin fails++; $display("FAIL ovf_window_count: got %0d, required %0d", win_cnt - w0, NWIN); end
    tests++; if (q.size() != 0) begin fails++; $display("FAIL ovf_leftover: got %0d pending, required 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    int d0, w0, n;
    @(negedge clk);
    push_frame();
    for (int r = 0; r < 3; r++) send_row(r, 1'b0);
    n = 0;
    while (!(win_valid_o && win_row_o == 8'd1 && win_col_o == 8'd2) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    tests++;
    if (win_row_o !== 8'd1 || win_col_o !== 8'd2) begin
      fails++;
      $display("FAIL mid_reset_point: got (%0d,%0d), required (1,2)", win_row_o, win_col_o);
    end
    rst_n = 1'b0;
    #1;
    tests++; if (row_ready_o !== 1'b1) begin fails++; $display("FAIL mid_reset_row_ready: got %b, required 1", row_ready_o); end
    tests++; if (win_valid_o !== 1'b0) begin fails++; $display("FAIL mid_reset_win_valid: got %b, required 0", win_valid_o); end
    tests++; if (win_o !== '0) begin fails++; $display("FAIL mid_reset_win: got %h, required 0", win_o); end
    tests++; if (win_row_o !== 8'd0 || win_col_o !== 8'd0) begin fails++; $display("FAIL mid_reset_rowcol: got (%0d,%0d), required (0,0)", win_row_o, win_col_o); end
    tests++; if (overflow_o !== 1'b0 || frame_done_o !== 1'b0) begin fails++; $display("FAIL mid_reset_flags: got ovf=%b done=%b, required 0 0", overflow_o, frame_done_o); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    w0 = win_cnt;
    @(negedge clk);
    push_frame();
    for (int r = 0; r < H; r++) send_row(r, 1'b0);
    wait_done(d0);
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL post_reset_done_count: got %0d, required 1", done_cnt - d0); end
    tests++; if (win_cnt - w0 != NWIN) begin fails++; $display("FAIL post_reset_window_count: got %0d, required %0d", win_cnt - w0, NWIN); end
    tests++; if (q.size() != 0) begin fails++; $display("FAIL post_reset_leftover: got %0d pending, required 0", q.size()); end
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL post_reset_overflow: got %b, required 0", overflow_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    row_valid_i = 1'b0;
    row_i = '0;
    win_ready_i = 1'b1;
    test_reset();
    test_frame();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/row_window_gen.md
Name: row_window_gen

Overview:
- Consumes full feature-map rows produced by the serial-to-parallel row collector.
- Keeps a 3-row line buffer and emits one 3x3 activation window per output pixel, in raster order, to the downstream RepVGG 3x3 conv PE array.
- Applies zero padding of 1 at all image borders.
- Valid/ready handshake on both sides; frame length is H rows.

Parameters:
- DW, 32, bits per activation word
- DP, 56, words per row (image width)
- H, 56, rows per frame (image height); H >= 3 is required

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- row_i  in  DW*DP  parallel row; word c sits at [c*DW +: DW]
- row_valid_i  in  1  row_i holds a complete row
- row_ready_o  out  1  block can accept a row this cycle
- win_o  out  9*DW  window; element (k,j) at [(k*3+j)*DW +: DW]; k=0 is the row above, j=0 is the column to the left
- win_valid_o  out  1  win_o is valid
- win_ready_i  in  1  consumer accepts win_o
- win_row_o  out  8  centre row index of the current window
- win_col_o  out  8  centre column index of the current window
- frame_done_o  out  1  one-cycle pulse when the last window of a frame is accepted
- overflow_o  out  1  sticky flag: a row was offered while row_ready_o=0

Behaviour:
- Reset (asynchronous, active-low; clock clk):
  - state=IDLE; line buffers top/mid/bot = 0; counters = 0.
  - Outputs after reset: row_ready_o=1, win_valid_o=0, win_o=0, win_row_o=0, win_col_o=0, frame_done_o=0, overflow_o=0.
- Row accept: row_valid_i & row_ready_o. On accept, the buffers shift: top<=mid, mid<=bot, bot<=row_i.
- State machine (with padding):
  - IDLE: row_ready_o=1. On accept (row 0) -> WAIT.
  - WAIT: row_ready_o=1. On accept -> EMIT, out_row<=out_row (0 for first entry), col<=0.
  - EMIT: row_ready_o=0, win_valid_o=1. The window is built combinationally from top/mid/bot and col.
  - Columns c-1 and c+1 read as zero when they fall outside 0..DP-1.
  - For out_row 0, top is already 0 because the buffers were cleared at frame start.
  - On win_valid_o & win_ready_i: col increments.
  - At col=DP-1 accept, when out_row < H-2: out_row++, col<=0, -> WAIT.
  - At col=DP-1 accept, when out_row = H-2: internal zero shift (top<=mid, mid<=bot, bot<=0), out_row<=H-1, stay in EMIT.
  - At col=DP-1 accept, when out_row = H-1: frame_done_o pulses the next cycle, buffers and counters clear, -> IDLE.
- Latency: the first window is valid the cycle after row 1 is accepted. Each window holds stable until accepted. One window per cycle under continuous win_ready_i.
- Backpressure: win_o, win_row_o and win_col_o hold while win_valid_o & !win_ready_i.
- Overflow: row_valid_i while row_ready_o=0 drops the row; overflow_o<=1 and stays set until reset. Buffers are unaffected.
- A row offered in the same cycle as the final window accept is dropped and flags overflow, because row_ready_o=0 that cycle.
- Counters are 8 bits wide; DP and H must be <= 256.
- Reset mid-frame: immediate return to the reset state; the partial frame is discarded.

Optional Feature:
- Macro: WIN_PAD_EN.
- Defined: zero padding as above; H*DP windows per frame.
- Undefined: no padding; only interior windows are emitted.
  - Emission begins after row 2 is accepted; out_row runs 1..H-2 and col runs 1..DP-2.
  - No zero-shift flush: after out_row = H-2 completes, frame_done_o pulses and the block returns to IDLE.
  - (H-2)*(DP-2) windows per frame.

Test Plan:
- Bench setup: DW=32, DP=4, H=3. Row r word c = {r[15:0],c[15:0]}.
- Padded frame, win_ready_i=1: offer rows 0..2 -> exactly 12 windows in raster order.
  - Window (0,0) = {0,0,0, 0,0x00000000,0x00000001, 0,0x00010000,0x00010001}.
  - frame_done_o pulses once after window (2,3).
- Backpressure: drop win_ready_i for 5 cycles mid-row -> win_o, win_row_o and win_col_o are stable; no window is skipped or duplicated.
- Overflow: hold row_valid_i=1 continuously -> rows are taken only in IDLE/WAIT; overflow_o=1 after the first EMIT cycle with row_valid_i=1; window contents stay correct.
- Reset mid-EMIT (out_row=1, col=2) -> all outputs return to reset values; a following full frame produces correct windows from row 0.
- WIN_PAD_EN undefined, DP=4, H=4 -> exactly 4 windows, centres (1,1),(1,2),(2,1),(2,2); window (1,1) = rows 0..2, cols 0..2; frame_done_o pulses after (2,2).
